// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM state encoding
//   F3_*         : RV32I load/store funct3 encodings
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_bytelane_ram.sv
// dmem_bytelane_ram: DEPTH_WORDS x 32 storage with per-byte write enables.
// Synchronous write, combinational read, contents are never reset.
// Ports:
//   clk   : clock
//   we    : byte-lane write enables, bit n writes wdata[8n+7:8n]
//   addr  : word index, shared by read and write
//   wdata : write data, already steered onto its lanes
//   rdata : word currently stored at addr
module dmem_bytelane_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I load/store interface.
// Accepts one request at a time, waits WAIT_STATES cycles, performs the
// access and presents a one-cycle response with load data or an error flag.
// Optional feature macro: DMEM_PERF_EN adds transaction counters.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_we          : 1 = store, 0 = load
//   req_addr        : byte address
//   req_wdata       : store data, right-justified
//   req_funct3      : RV32I load/store funct3
//   rsp_valid       : one-cycle response strobe
//   rsp_rdata       : extended load data, 0 for stores and errors
//   rsp_err         : access fault, qualified by rsp_valid
//   perf_loads/stores/errs (DMEM_PERF_EN only) : completed transaction counts
//
// state | meaning
// IDLE  | ready for a request; with WAIT_STATES=0 the access happens on accept
// WAIT  | counting down wait states; access happens as the count reaches 0
// RESP  | rsp_valid high for this single cycle
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [15:0] perf_errs
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        access;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_f3;
    logic [31:0] off;
    logic        f3_bad;
    logic        misalign;
    logic        out_of_range;
    logic        acc_err;
    logic [4:0]  lane_sh;
    logic [31:0] ram_rdata;
    logic [31:0] rd_shifted;
    logic [31:0] load_val;
    logic [3:0]  lane_mask;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    // With zero wait states the access occurs on the accept edge, so the
    // live request fields are used instead of the not-yet-latched copies.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_f3    = f3_q;
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_f3    = req_funct3;
        end
    end

    always_comb begin
        off    = acc_addr - BASE_ADDR;
        f3_bad = 1'b0;
        if (acc_we) begin
            f3_bad = !(acc_f3 == F3_B || acc_f3 == F3_H || acc_f3 == F3_W);
        end else begin
            f3_bad = !(acc_f3 == F3_B || acc_f3 == F3_H || acc_f3 == F3_W ||
                       acc_f3 == F3_BU || acc_f3 == F3_HU);
        end
        // funct3[1:0] encodes access size for every legal load/store
        misalign     = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                       ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        out_of_range = ({1'b0, off} >= SPAN);
        acc_err      = f3_bad || misalign || out_of_range;
    end

    always_comb begin
        lane_sh    = {acc_addr[1:0], 3'b000};
        rd_shifted = ram_rdata >> lane_sh;
        load_val   = 32'h0;
        case (acc_f3)
            F3_B:    load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_H:    load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_W:    load_val = rd_shifted;
            F3_BU:   load_val = {24'h0, rd_shifted[7:0]};
            F3_HU:   load_val = {16'h0, rd_shifted[15:0]};
            default: load_val = 32'h0;
        endcase

        lane_mask = 4'b0000;
        case (acc_f3)
            F3_B:    lane_mask = 4'b0001 << acc_addr[1:0];
            F3_H:    lane_mask = 4'b0011 << acc_addr[1:0];
            F3_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        ram_wdata = acc_wdata << lane_sh;
        ram_we    = (access && acc_we && !acc_err) ? lane_mask : 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (access) begin
                rdata_q <= (acc_we || acc_err) ? 32'h0 : load_val;
                err_q   <= acc_err;
            end else if (state_q == RESP) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    dmem_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (off[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_loads  <= 32'h0;
            perf_stores <= 32'h0;
            perf_errs   <= 16'h0;
        end else if (state_q == RESP) begin
            if (err_q) begin
                perf_errs <= perf_errs + 16'd1;
            end else if (we_q) begin
                perf_stores <= perf_stores + 32'd1;
            end else begin
                perf_loads <= perf_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder.
// dut  : WAIT_STATES=2, main load/store/error sequence
// dut0 : WAIT_STATES=0, back-to-back acceptance
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;
    logic        v0, rdy0, we0, rv0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [2:0]  f30;
`ifdef DMEM_PERF_EN
    logic [31:0] pl, ps, pl0, ps0;
    logic [15:0] pe, pe0;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_PERF_EN
        , .perf_loads(pl), .perf_stores(ps), .perf_errs(pe)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wdata0), .req_funct3(f30),
        .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0)
`ifdef DMEM_PERF_EN
        , .perf_loads(pl0), .perf_stores(ps0), .perf_errs(pe0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request on dut, starting and ending at a falling edge.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_d, input logic exp_e);
        exp_t x;
        exp_t got;
        int   n;
        int   lat;
        x.tag = tag; x.d = exp_d; x.e = exp_e;
        sb.push_back(x);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = sb.pop_front();
        check({got.tag, "_latency"}, 32'(lat), 32'd3);
        check({got.tag, "_ready_in_resp"}, {31'h0, req_ready}, 32'h0);
        check({got.tag, "_rdata"}, rsp_rdata, got.d);
        check({got.tag, "_err"}, {31'h0, rsp_err}, {31'h0, got.e});
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int rsp;
        int seen;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        v0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; f30 = '0;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        xact("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0);
        xact("lw_10", 1'b0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0);
        xact("lb_13", 1'b0, 32'h13, 32'h0, F3_B, 32'hFFFFFFDE, 1'b0);
        xact("lbu_13", 1'b0, 32'h13, 32'h0, F3_BU, 32'h000000DE, 1'b0);
        xact("lh_12", 1'b0, 32'h12, 32'h0, F3_H, 32'hFFFFDEAD, 1'b0);
        xact("lhu_10", 1'b0, 32'h10, 32'h0, F3_HU, 32'h0000BEEF, 1'b0);
        xact("sb_11", 1'b1, 32'h11, 32'h000000AA, F3_B, 32'h0, 1'b0);
        xact("lw_after_sb", 1'b0, 32'h10, 32'h0, F3_W, 32'hDEADAAEF, 1'b0);
        xact("sh_12", 1'b1, 32'h12, 32'h00001234, F3_H, 32'h0, 1'b0);
        xact("lw_after_sh", 1'b0, 32'h10, 32'h0, F3_W, 32'h1234AAEF, 1'b0);
        xact("lw_mis_12", 1'b0, 32'h12, 32'h0, F3_W, 32'h0, 1'b1);
        xact("sh_mis_11", 1'b1, 32'h11, 32'hFFFFFFFF, F3_H, 32'h0, 1'b1);
        xact("lw_oor_400", 1'b0, 32'h400, 32'h0, F3_W, 32'h0, 1'b1);
        xact("sw_oor_410", 1'b1, 32'h410, 32'h55555555, F3_W, 32'h0, 1'b1);
        xact("ld_f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        xact("st_f3_100", 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1);
        xact("lw_unchanged", 1'b0, 32'h10, 32'h0, F3_W, 32'h1234AAEF, 1'b0);
        xact("sw_3fc", 1'b1, 32'h3FC, 32'hA5A5_0F0F, F3_W, 32'h0, 1'b0);
        xact("lw_3fc", 1'b0, 32'h3FC, 32'h0, F3_W, 32'hA5A50F0F, 1'b0);
        xact("lh_3fe", 1'b0, 32'h3FE, 32'h0, F3_H, 32'hFFFFA5A5, 1'b0);

        // Back-to-back on the zero-wait-state instance with valid held high.
        v0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'hCAFEF00D; f30 = F3_W;
        @(posedge clk);
        @(negedge clk);
        check("b2b_sw_rsp", {31'h0, rv0}, 32'h1);
        we0 = 1'b0;
        acc = 0;
        rsp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdy0) acc++;
            if (rv0) begin
                rsp++;
                check("b2b_ready_in_resp", {31'h0, rdy0}, 32'h0);
                check("b2b_rdata", rdata0, 32'hCAFEF00D);
            end
        end
        v0 = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd6);
        check("b2b_responses", 32'(rsp), 32'd6);
        @(negedge clk);

        // Reset pulsed while a store is in WAIT: no write, no response.
        xact("sw_20", 1'b1, 32'h20, 32'h11112222, F3_W, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h99999999; req_funct3 = F3_W;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_wait", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        #2;
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        xact("lw_20_prior", 1'b0, 32'h20, 32'h0, F3_W, 32'h11112222, 1'b0);

`ifdef DMEM_PERF_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("perf_reset_loads", pl, 32'd0);
        xact("p_sw_30", 1'b1, 32'h30, 32'h01020304, F3_W, 32'h0, 1'b0);
        xact("p_sw_34", 1'b1, 32'h34, 32'h05060708, F3_W, 32'h0, 1'b0);
        xact("p_lw_30", 1'b0, 32'h30, 32'h0, F3_W, 32'h01020304, 1'b0);
        xact("p_lw_34", 1'b0, 32'h34, 32'h0, F3_W, 32'h05060708, 1'b0);
        xact("p_lw_10", 1'b0, 32'h10, 32'h0, F3_W, 32'h1234AAEF, 1'b0);
        xact("p_lw_mis", 1'b0, 32'h32, 32'h0, F3_W, 32'h0, 1'b1);
        check("perf_loads", pl, 32'd3);
        check("perf_stores", ps, 32'd2);
        check("perf_errs", {16'h0, pe}, 32'd1);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
